// File: rtl/resizer_pkg.sv
// Lane layout constants and small combinational helpers shared by the stream resizer blocks.
package resizer_pkg;

    localparam int KEEP_BIT  = 0;
    localparam int LAST_BIT  = 1;
    localparam int DATA_LSB  = 2;
    localparam int MAX_LANES = 32;

    function automatic int lane_w(input int t);
        return t + 2;
    endfunction

    function automatic int popcount(input logic [MAX_LANES-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

    // Index of the lowest set bit; MAX_LANES when no bit is set.
    function automatic int first_set(input logic [MAX_LANES-1:0] v);
        int idx;
        idx = MAX_LANES;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            idx = v[i] ? i : idx;
        end
        return idx;
    endfunction

    function automatic int wrap_add(input int base, input int off, input int depth);
        int s;
        s = base + off;
        return (s >= depth) ? (s - depth) : s;
    endfunction

endpackage

// File: rtl/lane_compactor.sv
// Packs the kept lanes of one input beat (up to the first end marker) into consecutive
// {data, last} slots, reporting how many were produced and whether the beat ended a packet.
module lane_compactor
    import resizer_pkg::*;
#(
    parameter int S_KEEP_WIDTH = 3,
    parameter int T_DATA_WIDTH = 1
) (
    input  logic [(T_DATA_WIDTH+2)*S_KEEP_WIDTH-1:0] beat_i,
    output logic [(T_DATA_WIDTH+1)*S_KEEP_WIDTH-1:0] lanes_o,
    output logic [$clog2(S_KEEP_WIDTH+1)-1:0]        count_o,
    output logic                                     last_o
);

    localparam int LW = lane_w(T_DATA_WIDTH);
    localparam int SW = T_DATA_WIDTH + 1;
    localparam int CW = $clog2(S_KEEP_WIDTH + 1);

    logic [S_KEEP_WIDTH-1:0] keep_s;
    logic [MAX_LANES-1:0]    last_s;
    logic [MAX_LANES-1:0]    kept_s;
    int                      first_last_s;
    int                      pos_s;

    // Extract flags and mask off every lane above the first end marker.
    always_comb begin
        keep_s = '0;
        last_s = '0;
        kept_s = '0;
        for (int i = 0; i < S_KEEP_WIDTH; i++) begin
            keep_s[i] = beat_i[i*LW + KEEP_BIT];
            last_s[i] = beat_i[i*LW + LAST_BIT];
        end
        first_last_s = first_set(last_s);
        for (int i = 0; i < S_KEEP_WIDTH; i++) begin
            kept_s[i] = keep_s[i] && (i <= first_last_s);
        end
    end

    // Prefix-sum placement; the end marker rides on the final packed lane.
    always_comb begin
        lanes_o = '0;
        pos_s   = 0;
        for (int i = 0; i < S_KEEP_WIDTH; i++) begin
            lanes_o[pos_s*SW +: SW] = kept_s[i] ? {beat_i[i*LW + DATA_LSB +: T_DATA_WIDTH], 1'b0}
                                                : lanes_o[pos_s*SW +: SW];
            pos_s = pos_s + (kept_s[i] ? 1 : 0);
        end
        count_o = CW'(popcount(kept_s));
        last_o  = (last_s != '0);
        if (last_o && (pos_s > 0)) begin
            lanes_o[(pos_s-1)*SW] = 1'b1;
        end else begin
            lanes_o[0] = lanes_o[0];
        end
    end

endmodule

// File: rtl/lane_resize_buffer.sv
// Lane-granular elastic buffer: compacted input lanes enter a circular slot array and leave
// as registered output beats of M lanes, cut short at packet ends.
module lane_resize_buffer
    import resizer_pkg::*;
#(
    parameter int S_KEEP_WIDTH = 3,
    parameter int M_KEEP_WIDTH = 2,
    parameter int T_DATA_WIDTH = 1,
    parameter int DEPTH        = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [(T_DATA_WIDTH+2)*S_KEEP_WIDTH-1:0] slave_entry,
    input  logic                                     slave_entry_valid,
    output logic                                     slave_entry_ready,
    output logic [(T_DATA_WIDTH+2)*M_KEEP_WIDTH-1:0] master_entry,
    output logic                                     master_entry_valid,
    input  logic                                     master_entry_ready,
    output logic [$clog2(DEPTH+1)-1:0]               level,
    output logic                                     overflow,
    output logic                                     underflow
);

    localparam int LW  = lane_w(T_DATA_WIDTH);
    localparam int SW  = T_DATA_WIDTH + 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVW = $clog2(DEPTH + 1);
    localparam int CW  = $clog2(S_KEEP_WIDTH + 1);
    localparam int NW  = $clog2(M_KEEP_WIDTH + 1);

    logic [SW-1:0]              mem_q [DEPTH];
    logic [SW-1:0]              mem_d [DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVW-1:0]             level_q, level_d;
    logic                       ready_q, ready_d;
    logic [LW*M_KEEP_WIDTH-1:0] out_q, out_d, beat_s;
    logic                       valid_q, valid_d;
    logic [NW-1:0]              n_q, n_d;
    logic                       overflow_q, underflow_q;

    logic [SW*S_KEEP_WIDTH-1:0] cmp_lanes_s;
    logic [CW-1:0]              cmp_count_s;
    logic                       cmp_last_s;
    logic                       wr_en_s, pop_s, hold_s, mark_s, stop_s, take_s;
    logic [PW-1:0]              tail_idx_s;
    logic [SW-1:0]              slot_s;
    int                         wr_cnt_s, pop_cnt_s, lvl_s, cnt_s;

    lane_compactor #(
        .S_KEEP_WIDTH (S_KEEP_WIDTH),
        .T_DATA_WIDTH (T_DATA_WIDTH)
    ) u_compactor (
        .beat_i  (slave_entry),
        .lanes_o (cmp_lanes_s),
        .count_o (cmp_count_s),
        .last_o  (cmp_last_s)
    );

    // Next slot contents, pointers and level; write and pop may share an edge.
    always_comb begin
        wr_en_s   = slave_entry_valid && ready_q;
        pop_s     = valid_q && master_entry_ready;
        wr_cnt_s  = wr_en_s ? int'(cmp_count_s) : 0;
        pop_cnt_s = pop_s ? int'(n_q) : 0;
        mem_d     = mem_q;
        for (int k = 0; k < S_KEEP_WIDTH; k++) begin
            mem_d[PW'(wrap_add(int'(wr_ptr_q), k, DEPTH))] =
                (k < wr_cnt_s) ? cmp_lanes_s[k*SW +: SW]
                               : mem_d[PW'(wrap_add(int'(wr_ptr_q), k, DEPTH))];
        end
        // An empty beat carrying last closes the packet on the tail slot if it survives this pop.
        tail_idx_s = PW'(wrap_add(int'(wr_ptr_q), DEPTH - 1, DEPTH));
        mark_s     = wr_en_s && (cmp_count_s == '0) && cmp_last_s && (int'(level_q) > pop_cnt_s);
        mem_d[tail_idx_s][0] = mark_s ? 1'b1 : mem_d[tail_idx_s][0];
        wr_ptr_d = PW'(wrap_add(int'(wr_ptr_q), wr_cnt_s, DEPTH));
        rd_ptr_d = PW'(wrap_add(int'(rd_ptr_q), pop_cnt_s, DEPTH));
        lvl_s    = int'(level_q) + wr_cnt_s - pop_cnt_s;
        level_d  = LVW'(lvl_s);
        ready_d  = (DEPTH - lvl_s) >= S_KEEP_WIDTH;
    end

    // Next output beat from the post-edge head, frozen while a presented beat is stalled.
    always_comb begin
        hold_s = valid_q && !master_entry_ready;
        beat_s = '0;
        stop_s = 1'b0;
        cnt_s  = 0;
        take_s = 1'b0;
        slot_s = '0;
        for (int j = 0; j < M_KEEP_WIDTH; j++) begin
            slot_s = mem_d[PW'(wrap_add(int'(rd_ptr_d), j, DEPTH))];
            take_s = !stop_s && (j < lvl_s);
            beat_s[j*LW +: LW] = take_s ? {slot_s[SW-1:1], slot_s[0], 1'b1} : '0;
            cnt_s  = cnt_s + (take_s ? 1 : 0);
            stop_s = stop_s || (take_s && slot_s[0]);
        end
        out_d   = hold_s ? out_q : beat_s;
        valid_d = hold_s ? valid_q : ((cnt_s == M_KEEP_WIDTH) || stop_s);
        n_d     = hold_s ? n_q : NW'(cnt_s);
    end

    // State, output and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_q     <= 1'b0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            n_q         <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            n_q         <= n_d;
            overflow_q  <= slave_entry_valid && !ready_q;
            underflow_q <= master_entry_ready && !valid_q;
        end
    end

    assign slave_entry_ready  = ready_q;
    assign master_entry       = out_q;
    assign master_entry_valid = valid_q;
    assign level              = level_q;
    assign overflow           = overflow_q;
    assign underflow          = underflow_q;

endmodule

// File: tb/tb_lane_resize_buffer.sv
// Bench for lane_resize_buffer: a lane-queue reference model checked every cycle, plus
// hand-computed beats that pin the model, then randomized traffic.
module tb_lane_resize_buffer;

    localparam int S     = 3;
    localparam int M     = 2;
    localparam int T     = 1;
    localparam int DEPTH = 8;
    localparam int LW    = T + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [LW*S-1:0] slave_entry;
    logic            slave_entry_valid;
    logic            slave_entry_ready;
    logic [LW*M-1:0] master_entry;
    logic            master_entry_valid;
    logic            master_entry_ready;
    logic [3:0]      level;
    logic            overflow;
    logic            underflow;

    int n_pass  = 0;
    int n_total = 0;

    lane_resize_buffer #(
        .S_KEEP_WIDTH (S),
        .M_KEEP_WIDTH (M),
        .T_DATA_WIDTH (T),
        .DEPTH        (DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .slave_entry        (slave_entry),
        .slave_entry_valid  (slave_entry_valid),
        .slave_entry_ready  (slave_entry_ready),
        .master_entry       (master_entry),
        .master_entry_valid (master_entry_valid),
        .master_entry_ready (master_entry_ready),
        .level              (level),
        .overflow           (overflow),
        .underflow          (underflow)
    );

    always #5 clk = ~clk;

    // Reference state: stored lanes as a queue, each entry = (data << 1) | last.
    int              q[$];
    logic            exp_ready, exp_valid, exp_ovf, exp_udf;
    logic [LW*M-1:0] exp_entry;
    int              exp_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic model_reset();
        q.delete();
        exp_ready = 1'b0;
        exp_valid = 1'b0;
        exp_entry = '0;
        exp_n     = 0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    task automatic model_present();
        int   avail;
        logic seen_last;
        int   lane;
        exp_entry = '0;
        exp_n     = 0;
        seen_last = 1'b0;
        avail     = (q.size() < M) ? q.size() : M;
        for (int j = 0; j < avail; j++) begin
            if (!seen_last) begin
                lane = ((q[j] >> 1) << 2) | ((q[j] & 1) << 1) | 1;
                exp_entry[j*LW +: LW] = LW'(lane);
                exp_n++;
                seen_last = (q[j] & 1) != 0;
            end
        end
        exp_valid = (q.size() >= M) || seen_last;
    endtask

    task automatic model_step(input logic [LW*S-1:0] beat, input logic sv, input logic mr);
        logic stalled, saw_last;
        stalled = exp_valid && !mr;
        exp_ovf = sv && !exp_ready;
        exp_udf = mr && !exp_valid;
        if (exp_valid && mr) begin
            for (int j = 0; j < exp_n; j++) void'(q.pop_front());
        end
        if (sv && exp_ready) begin
            saw_last = 1'b0;
            for (int i = 0; i < S; i++) begin
                if (!saw_last) begin
                    if (beat[i*LW]) q.push_back(int'(beat[i*LW+2 +: T]) << 1);
                    saw_last = beat[i*LW+1];
                end
            end
            if (saw_last && q.size() > 0) q[q.size()-1] = q[q.size()-1] | 1;
        end
        if (!stalled) model_present();
        exp_ready = (DEPTH - q.size()) >= S;
    endtask

    // Model advances on the same edges (and async reset) as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(slave_entry, slave_entry_valid, master_entry_ready);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("entry",     32'(master_entry),       32'(exp_entry));
            check("valid",     32'(master_entry_valid), 32'(exp_valid));
            check("s_ready",   32'(slave_entry_ready),  32'(exp_ready));
            check("level",     32'(level),              32'(q.size()));
            check("overflow",  32'(overflow),           32'(exp_ovf));
            check("underflow", 32'(underflow),          32'(exp_udf));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [LW*S-1:0] b, input logic sv, input logic mr);
        slave_entry        = b;
        slave_entry_valid  = sv;
        master_entry_ready = mr;
    endtask

    logic [LW*S-1:0] rnd_beat;

    initial begin
        drive('0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ready", 32'(slave_entry_ready), 32'd0);
        check("rst_entry", 32'(master_entry), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check("ready_first_edge", 32'(slave_entry_ready), 32'd1);

        drive(9'b101001101, 1'b1, 1'b1); tick();
        check("full_entry", 32'(master_entry), 32'b001101);
        check("full_valid", 32'(master_entry_valid), 32'd1);
        drive('0, 1'b0, 1'b1); tick();
        check("full_pop_level", 32'(level), 32'd1);
        check("full_pop_valid", 32'(master_entry_valid), 32'd0);

        drive(9'b000000010, 1'b1, 1'b1); tick();
        check("tail_mark_entry", 32'(master_entry), 32'b000111);
        drive('0, 1'b0, 1'b1); tick();

        drive(9'b000000111, 1'b1, 1'b1); tick();
        check("flush_entry", 32'(master_entry), 32'b000111);
        check("flush_valid", 32'(master_entry_valid), 32'd1);
        drive('0, 1'b0, 1'b1); tick();
        check("flush_level", 32'(level), 32'd0);

        drive(9'b001101000, 1'b1, 1'b1); tick();
        check("sparse_entry", 32'(master_entry), 32'b001101);
        drive('0, 1'b0, 1'b1); tick();
        check("sparse_level", 32'(level), 32'd0);
        tick();
        check("underflow", 32'(underflow), 32'd1);

        drive(9'b101101101, 1'b1, 1'b0); tick(); tick();
        check("fill_level", 32'(level), 32'd6);
        check("fill_ready", 32'(slave_entry_ready), 32'd0);
        tick();
        check("overflow_1", 32'(overflow), 32'd1);
        tick();
        check("overflow_2", 32'(overflow), 32'd1);
        check("held_entry", 32'(master_entry), 32'b101101);
        drive('0, 1'b0, 1'b1); tick();
        check("drain_level", 32'(level), 32'd4);
        check("drain_ready", 32'(slave_entry_ready), 32'd1);
        tick(); tick();

        drive(9'b101101101, 1'b1, 1'b0); tick();
        drive(9'b000101101, 1'b1, 1'b0); tick();
        check("pre_reset_level", 32'(level), 32'd5);
        slave_entry_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_level", 32'(level), 32'd0);
        check("async_valid", 32'(master_entry_valid), 32'd0);
        check("async_ready", 32'(slave_entry_ready), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post_reset_ready", 32'(slave_entry_ready), 32'd1);
        drive(9'b000111101, 1'b1, 1'b1); tick();
        check("fresh_entry", 32'(master_entry), 32'b111101);
        drive('0, 1'b0, 1'b1); tick();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < S; i++) begin
                rnd_beat[i*LW]     = ($urandom % 4) != 0;
                rnd_beat[i*LW + 1] = ($urandom % 6) == 0;
                rnd_beat[i*LW + 2] = $urandom % 2;
            end
            drive(rnd_beat, ($urandom % 3) != 0,
                  ((c / 300) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
